// File: rtl/bus_seq.sv
// Register-transfer bus sequencer: request FIFO feeding a two-stage issue/load pipeline.
// Optional hazard bubble is compiled in when BUS_SEQ_HAZARD_EN is defined.
module bus_seq #(
  parameter int DEPTH = 4
) (
  input  logic                   ph1,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [2:0]             req_src,
  input  logic [2:0]             req_dst,
  output logic                   req_ready,
  input  logic                   hold,
  output logic [7:0]             o_en,
  output logic [7:0]             i_en,
  output logic [$clog2(DEPTH):0] count,
  output logic                   bus_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0] src;
    logic [2:0] dst;
  } req_t;

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          r_s_valid;
  logic [2:0]    r_s_src;
  logic [2:0]    r_s_dst;
  logic          r_l_valid;
  logic [2:0]    r_l_dst;

  req_t          w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_hazard;

  assign w_head    = r_mem[r_rd_ptr];
  assign req_ready = (r_count < FULL) && !reset;
  assign w_push    = req_valid && req_ready;

`ifdef BUS_SEQ_HAZARD_EN
  // The issuing transfer writes the register the head wants to read; insert one bubble.
  assign w_hazard  = r_s_valid && (w_head.src == r_s_dst);
`else
  assign w_hazard  = 1'b0;
`endif

  assign w_pop = (r_count != '0) && !hold && !w_hazard;

  // NOTE: FIFO storage is deliberately not reset; occupancy and pointers alone define validity.
  always_ff @(posedge ph1) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{src: req_src, dst: req_dst};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_s_valid <= 1'b0;
      r_l_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase

      r_l_valid <= r_s_valid;
      r_s_valid <= w_pop;
    end
  end

  // Data fields carry no reset; their valid bits gate every use.
  always_ff @(posedge ph1) begin
    r_l_dst <= r_s_dst;
    if (w_pop) begin
      r_s_src <= w_head.src;
      r_s_dst <= w_head.dst;
    end
  end

  assign o_en     = r_s_valid ? (8'h01 << r_s_src) : 8'h00;
  assign i_en     = r_l_valid ? (8'h01 << r_l_dst) : 8'h00;
  assign count    = r_count;
  assign bus_busy = r_s_valid || r_l_valid || (r_count != '0);

endmodule

// File: tb/tb_bus_seq.sv
// Self-checking bench for bus_seq: directed scenarios plus random traffic against a queue-based model.
module tb_bus_seq;

  localparam int DEPTH = 4;
`ifdef BUS_SEQ_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic       ph1 = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_src = '0;
  logic [2:0] req_dst = '0;
  logic       hold = 1'b0;
  logic       req_ready;
  logic [7:0] o_en;
  logic [7:0] i_en;
  logic [$clog2(DEPTH):0] count;
  logic       bus_busy;

  int n_vec  = 0;
  int n_fail = 0;

  bus_seq #(.DEPTH(DEPTH)) dut (
    .ph1(ph1), .reset(reset), .req_valid(req_valid), .req_src(req_src),
    .req_dst(req_dst), .req_ready(req_ready), .hold(hold), .o_en(o_en),
    .i_en(i_en), .count(count), .bus_busy(bus_busy)
  );

  always #5 ph1 = ~ph1;

  // Reference model: a plain queue of pending transfers plus the issued and loading transfer.
  typedef struct packed {
    logic [2:0] src;
    logic [2:0] dst;
  } req_t;

  req_t q[$];
  bit   m_issue_v = 1'b0;
  req_t m_issue;
  bit   m_load_v = 1'b0;
  req_t m_load;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input req_t r, input bit h, input bit rst);
    bit   can_pop;
    bit   take;
    if (rst) begin
      q.delete();
      m_issue_v = 1'b0;
      m_load_v  = 1'b0;
    end else begin
      take    = v && (q.size() < DEPTH);
      can_pop = (q.size() != 0) && !h &&
                !(HAZ && m_issue_v && (q[0].src == m_issue.dst));
      m_load_v = m_issue_v;
      m_load   = m_issue;
      m_issue_v = can_pop;
      if (can_pop) m_issue = q.pop_front();
      if (take) q.push_back(r);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare every output just after it.
  task automatic cycle(input bit v, input logic [2:0] s, input logic [2:0] d,
                       input bit h, input bit rst);
    req_t r;
    r = '{src: s, dst: d};
    req_valid = v;
    req_src   = s;
    req_dst   = d;
    hold      = h;
    reset     = rst;
    @(posedge ph1);
    model_edge(v, r, h, rst);
    #1;
    chk("o_en",      32'(o_en),      m_issue_v ? 32'(8'h01 << m_issue.src) : 32'h0);
    chk("i_en",      32'(i_en),      m_load_v  ? 32'(8'h01 << m_load.dst)  : 32'h0);
    chk("count",     32'(count),     32'(q.size()));
    chk("req_ready", 32'(req_ready), 32'((q.size() < DEPTH) && !rst));
    chk("bus_busy",  32'(bus_busy),  32'(m_issue_v || m_load_v || (q.size() != 0)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state, with req_valid asserted to show it is ignored.
    cycle(1'b1, 3'd1, 3'd1, 1'b0, 1'b1);
    cycle(1'b1, 3'd2, 3'd2, 1'b0, 1'b1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_busy",  32'(bus_busy), 32'h0);

    // Single request 2 -> 5.
    cycle(1'b1, 3'd2, 3'd5, 1'b0, 1'b0);
    chk("single_cnt", 32'(count), 32'h1);
    cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("single_o", 32'(o_en), 32'h04);
    chk("single_i0", 32'(i_en), 32'h00);
    cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("single_o0", 32'(o_en), 32'h00);
    chk("single_i", 32'(i_en), 32'h20);
    cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("single_busy", 32'(bus_busy), 32'h0);

    // Full and backpressure under hold.
    for (int k = 0; k < 4; k++) cycle(1'b1, 3'(k + 4), 3'(k), 1'b1, 1'b0);
    chk("full_cnt", 32'(count), 32'h4);
    chk("full_ready", 32'(req_ready), 32'h0);
    cycle(1'b1, 3'd7, 3'd7, 1'b1, 1'b0);
    chk("full_5th", 32'(count), 32'h4);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
      chk("drain_o", 32'(o_en), 32'(8'h01 << (k + 4)));
    end
    cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("drain_last_i", 32'(i_en), 32'h08);
    idle(2);

    // Dependency 1->3 followed by 3->6.
    cycle(1'b1, 3'd1, 3'd3, 1'b0, 1'b0);
    cycle(1'b1, 3'd3, 3'd6, 1'b0, 1'b0);
    chk("haz_o1", 32'(o_en), 32'h02);
    cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("haz_o2", 32'(o_en), HAZ ? 32'h00 : 32'h08);
    cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("haz_o3", 32'(o_en), HAZ ? 32'h08 : 32'h00);
    idle(3);

    // Reset mid-operation: three queued, one issued.
    for (int k = 0; k < 4; k++) cycle(1'b1, 3'(k), 3'(7 - k), 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("mid_cnt", 32'(count), 32'h3);
    cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    chk("mid_o", 32'(o_en), 32'h0);
    chk("mid_i", 32'(i_en), 32'h0);
    chk("mid_cnt0", 32'(count), 32'h0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
      chk("mid_quiet", 32'(o_en | i_en), 32'h0);
    end

    // Wrap-around: push with a concurrent pop each cycle, ids 0..7,0,1.
    cycle(1'b1, 3'd0, 3'd1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 3'(k % 8), 3'((k + 3) % 8), 1'b0, 1'b0);
      chk("wrap_cnt", 32'(count <= DEPTH), 32'h1);
      if (k > 0) chk("wrap_o", 32'(o_en), 32'(8'h01 << ((k - 1) % 8)));
    end
    idle(4);

    // Random traffic with occasional hold and reset.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 60) == 0));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_seq.md
BUS_SEQ -- requirements
Module: bus_seq

Interface
REQ-001 SHALL have parameter: DEPTH, 4, request FIFO entries (power of two, >=2).
REQ-002 SHALL have port: ph1  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  transfer request present.
REQ-005 SHALL have port: req_src  input  3  source register id driving x_bus.
REQ-006 SHALL have port: req_dst  input  3  destination register id loading from y_bus.
REQ-007 SHALL have port: req_ready  output  1  FIFO can accept a request this cycle.
REQ-008 SHALL have port: hold  input  1  freeze issue; no FIFO pop while high.
REQ-009 SHALL have port: o_en  output  8  one-hot source output enable, or all zero.
REQ-010 SHALL have port: i_en  output  8  one-hot destination input enable, or all zero.
REQ-011 SHALL have port: count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-012 SHALL have port: bus_busy  output  1  any request queued or in flight.

Function
REQ-013 SHALL accept a request on an edge where req_valid and req_ready are both high, and push {src,dst} into the FIFO.
REQ-014 SHALL drive req_ready = (count < DEPTH) and not reset; there is no same-cycle pass-through when full.
REQ-015 SHALL keep FIFO order; read and write pointers wrap modulo DEPTH.
REQ-016 SHALL keep count unchanged on a simultaneous push and pop; it SHALL never exceed DEPTH or underflow.
REQ-017 SHALL hold a two-stage pipeline:
- issue stage S = {valid, src, dst}
- load stage L = {valid, dst}
- every edge: L <= S.
REQ-018 SHALL pop the FIFO head into S on each edge where count != 0, hold = 0 and no hazard stall applies; otherwise S.valid <= 0.
REQ-019 SHALL drive o_en = onehot(S.src) when S.valid, else 8'h00.
REQ-020 SHALL drive i_en = onehot(L.dst) when L.valid, else 8'h00.
REQ-021 SHALL give latency from an empty pipeline: accept at edge k, o_en valid after edge k+1, i_en valid after edge k+2.
REQ-022 SHALL allow src == dst within one request (read-modify-write through the ALU buffer).
REQ-023 SHALL drive bus_busy = S.valid | L.valid | (count != 0).
REQ-024 SHALL let hold mid-stream drain S and L normally while leaving FIFO contents intact.

Reset
REQ-025 SHALL, on any edge with reset high, set count = 0, both pointers = 0, S.valid = 0 and L.valid = 0, aborting in-flight transfers.
REQ-026 SHALL have all outputs 0 after a reset edge (o_en, i_en, count, bus_busy, and req_ready while reset is held).
REQ-027 SHALL ignore req_valid while reset is high.

Configuration
REQ-028 SHALL compile hazard detection when BUS_SEQ_HAZARD_EN is defined: no pop when S.valid and head.src == S.dst, so S is invalid for one cycle (bubble).
REQ-029 SHALL, without BUS_SEQ_HAZARD_EN, issue back-to-back regardless of register dependency; ordering is the requester's responsibility.

Verification
REQ-030 SHALL verify single request: reset, then src=2, dst=5 -> o_en=8'h04 for one cycle, next cycle i_en=8'h20, then bus_busy=0.
REQ-031 SHALL verify full/backpressure: hold=1, push 4 requests -> count=4 and req_ready=0, and a 5th request is not accepted; release hold -> 4 consecutive o_en pulses, each with its i_en one cycle later.
REQ-032 SHALL verify hazard: requests 1->3 then 3->6 back-to-back -> with BUS_SEQ_HAZARD_EN o_en = 02, 00, 08; without it o_en = 02, 08.
REQ-033 SHALL verify reset mid-operation: 3 queued, one in S, reset pulsed one cycle -> next cycle o_en=i_en=0, count=0, and no later enables appear.
REQ-034 SHALL verify wrap-around: 10 requests with ids 0..7,0,1 pushed, each push with a concurrent pop -> o_en order matches push order and count never exceeds DEPTH.
